iob_aclint: RTL

// - Parametrised successor of the single-config CLINT: per-hart machine timer (MTIMER) and software interrupt (MSWI) unit on an IOB slave port.
// - Sits between the system IOB interconnect and N_HARTS cores; drives mtip/msip per hart.
// - Adds an RTC prescaler, a synchronised RTC input, 64-bit atomic mtime reads and strobe-accurate writes.

---
 rtl/iob_aclint.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/iob_aclint.sv
// iob_aclint: per-hart machine timer (MTIMER) and software interrupt (MSWI) unit on an IOB slave port.
// Latency: read data/rvalid 1 clk after accept; mtime ticks RTC_SYNC_W+1 clk after an rtc_i rise, mtip_o 1 clk later.
// Backpressure: none; iob_ready_o is high whenever out of reset, so back-to-back accepts are taken every cycle.
// Build option: define IOB_ACLINT_SSWI_EN to add the SSWI bank at 0xC000 and the ssip_o port.
module iob_aclint #(
    parameter int N_HARTS    = 1,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int RTC_SYNC_W = 2,
    parameter int RTC_DIV    = 1
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  rtc_i,
    input  logic                  iob_avalid_i,
    input  logic [ADDR_W-1:0]     iob_addr_i,
    input  logic [DATA_W-1:0]     iob_wdata_i,
    input  logic [DATA_W/8-1:0]   iob_wstrb_i,
    output logic                  iob_ready_o,
    output logic                  iob_rvalid_o,
    output logic [DATA_W-1:0]     iob_rdata_o,
    output logic [N_HARTS-1:0]    mtip_o,
    output logic [N_HARTS-1:0]    msip_o
`ifdef IOB_ACLINT_SSWI_EN
    ,
    output logic [N_HARTS-1:0]    ssip_o
`endif
);

    // Word-address view of the register map (byte address >> 2).
    localparam int                WA_W        = ADDR_W - 2;
    localparam logic [WA_W-1:0]   WA_MSIP     = '0;
    localparam logic [WA_W-1:0]   WA_CMP      = WA_W'(32'h4000 >> 2);
    localparam logic [WA_W-1:0]   WA_MTIME_LO = WA_W'(32'hBFF8 >> 2);
    localparam logic [WA_W-1:0]   WA_MTIME_HI = WA_W'(32'hBFFC >> 2);
`ifdef IOB_ACLINT_SSWI_EN
    localparam logic [WA_W-1:0]   WA_SSWI     = WA_W'(32'hC000 >> 2);
`endif

    // Prescaler wide enough for RTC_DIV up to 2^16.
    localparam int                PRE_W       = 17;
    localparam logic [PRE_W-1:0]  PRE_MAX     = PRE_W'(RTC_DIV - 1);

    // Byte-strobe merge of a 32-bit register half.
    function automatic logic [31:0] f_merge(input logic [31:0] i_old,
                                            input logic [31:0] i_new,
                                            input logic [3:0]  i_strb);
        logic [31:0] v;
        v = i_old;
        for (int b = 0; b < 4; b++) begin
            if (i_strb[b]) v[8*b +: 8] = i_new[8*b +: 8];
        end
        return v;
    endfunction

    // State
    logic                    r_ready;
    logic                    r_rvalid;
    logic [DATA_W-1:0]       r_rdata;
    logic [31:0]             r_shadow;
    logic                    r_last_lo_rd;
    logic [RTC_SYNC_W-1:0]   r_sync;
    logic                    r_rtc_prev;
    logic [PRE_W-1:0]        r_pre;
    logic [63:0]             r_mtime;
    logic [63:0]             r_mtimecmp [N_HARTS];
    logic [N_HARTS-1:0]      r_msip;
    logic [N_HARTS-1:0]      r_mtip;
`ifdef IOB_ACLINT_SSWI_EN
    logic [N_HARTS-1:0]      r_ssip;
`endif

    // Decode / datapath wires
    logic [WA_W-1:0]         w_waddr;
    logic                    w_unused_addr;
    logic                    w_acc;
    logic                    w_wr;
    logic                    w_rd;
    logic                    w_sel_mtime_lo;
    logic                    w_sel_mtime_hi;
    logic [N_HARTS-1:0]      w_sel_msip;
    logic [N_HARTS-1:0]      w_sel_cmp_lo;
    logic [N_HARTS-1:0]      w_sel_cmp_hi;
`ifdef IOB_ACLINT_SSWI_EN
    logic [N_HARTS-1:0]      w_sel_ssip;
`endif
    logic [DATA_W-1:0]       w_rdata;
    logic                    w_rtc_rise;
    logic                    w_tick;
    logic                    w_mtime_wr;
    logic [63:0]             w_mtime_nxt;

    assign w_waddr        = iob_addr_i[ADDR_W-1:2];
    // Byte offset within a word does not affect decode.
    assign w_unused_addr  = ^iob_addr_i[1:0];
    assign w_acc          = iob_avalid_i & r_ready;
    assign w_wr           = w_acc & (|iob_wstrb_i);
    assign w_rd           = w_acc & ~(|iob_wstrb_i);
    assign w_sel_mtime_lo = (w_waddr == WA_MTIME_LO);
    assign w_sel_mtime_hi = (w_waddr == WA_MTIME_HI);

    // Per-hart address decode; harts beyond N_HARTS never match.
    always_comb begin
        w_sel_msip   = '0;
        w_sel_cmp_lo = '0;
        w_sel_cmp_hi = '0;
`ifdef IOB_ACLINT_SSWI_EN
        w_sel_ssip   = '0;
`endif
        for (int h = 0; h < N_HARTS; h++) begin
            w_sel_msip[h]   = (w_waddr == WA_MSIP + WA_W'(h));
            w_sel_cmp_lo[h] = (w_waddr == WA_CMP + WA_W'(2*h));
            w_sel_cmp_hi[h] = (w_waddr == WA_CMP + WA_W'(2*h + 1));
`ifdef IOB_ACLINT_SSWI_EN
            w_sel_ssip[h]   = (w_waddr == WA_SSWI + WA_W'(h));
`endif
        end
    end

    // Read mux; unmapped addresses read as zero.
    always_comb begin
        w_rdata = '0;
        if (w_sel_mtime_lo) w_rdata = r_mtime[31:0];
        if (w_sel_mtime_hi) w_rdata = r_last_lo_rd ? r_shadow : r_mtime[63:32];
        for (int h = 0; h < N_HARTS; h++) begin
            if (w_sel_msip[h])   w_rdata = {{(DATA_W-1){1'b0}}, r_msip[h]};
            if (w_sel_cmp_lo[h]) w_rdata = r_mtimecmp[h][31:0];
            if (w_sel_cmp_hi[h]) w_rdata = r_mtimecmp[h][63:32];
`ifdef IOB_ACLINT_SSWI_EN
            if (w_sel_ssip[h])   w_rdata = {{(DATA_W-1){1'b0}}, r_ssip[h]};
`endif
        end
    end

    // Bus response: ready after reset, one-cycle rvalid per read, hi-word shadow for atomic 64-bit reads.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_ready      <= 1'b0;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
            r_shadow     <= '0;
            r_last_lo_rd <= 1'b0;
        end else begin
            r_ready  <= 1'b1;
            r_rvalid <= w_rd;
            if (w_rd) r_rdata <= w_rdata;
            if (w_rd && w_sel_mtime_lo) r_shadow <= r_mtime[63:32];
            if (w_acc) r_last_lo_rd <= w_rd & w_sel_mtime_lo;
        end
    end

    // RTC edge detection after the synchroniser, and the tick at prescaler wrap.
    assign w_rtc_rise = r_sync[RTC_SYNC_W-1] & ~r_rtc_prev;
    assign w_tick     = w_rtc_rise & (r_pre == PRE_MAX);
    assign w_mtime_wr = w_wr & (w_sel_mtime_lo | w_sel_mtime_hi);

    // Synchronise rtc_i and count rising edges; an mtime write restarts the prescaler.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_sync     <= '0;
            r_rtc_prev <= 1'b0;
            r_pre      <= '0;
        end else begin
            r_sync     <= {r_sync[RTC_SYNC_W-2:0], rtc_i};
            r_rtc_prev <= r_sync[RTC_SYNC_W-1];
            if (w_mtime_wr) begin
                r_pre <= '0;
            end else if (w_rtc_rise) begin
                r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
            end
        end
    end

    // Next mtime: a bus write wins over a coincident tick for all 64 bits.
    always_comb begin
        w_mtime_nxt = r_mtime;
        if (w_mtime_wr) begin
            if (w_sel_mtime_lo) w_mtime_nxt[31:0]  = f_merge(r_mtime[31:0],  iob_wdata_i, iob_wstrb_i);
            if (w_sel_mtime_hi) w_mtime_nxt[63:32] = f_merge(r_mtime[63:32], iob_wdata_i, iob_wstrb_i);
        end else if (w_tick) begin
            w_mtime_nxt = r_mtime + 64'd1;
        end
    end

    // mtime register, free-running modulo 2^64.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_mtime <= '0;
        end else begin
            r_mtime <= w_mtime_nxt;
        end
    end

    // Per-hart mtimecmp and software-interrupt bits, byte-strobe writes.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int h = 0; h < N_HARTS; h++) r_mtimecmp[h] <= '1;
            r_msip <= '0;
`ifdef IOB_ACLINT_SSWI_EN
            r_ssip <= '0;
`endif
        end else if (w_wr) begin
            for (int h = 0; h < N_HARTS; h++) begin
                if (w_sel_cmp_lo[h])
                    r_mtimecmp[h][31:0]  <= f_merge(r_mtimecmp[h][31:0],  iob_wdata_i, iob_wstrb_i);
                if (w_sel_cmp_hi[h])
                    r_mtimecmp[h][63:32] <= f_merge(r_mtimecmp[h][63:32], iob_wdata_i, iob_wstrb_i);
                if (w_sel_msip[h] && iob_wstrb_i[0])
                    r_msip[h] <= iob_wdata_i[0];
`ifdef IOB_ACLINT_SSWI_EN
                if (w_sel_ssip[h] && iob_wstrb_i[0])
                    r_ssip[h] <= iob_wdata_i[0];
`endif
            end
        end
    end

    // Registered timer compare per hart (unsigned 64-bit).
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_mtip <= '0;
        end else begin
            for (int h = 0; h < N_HARTS; h++) r_mtip[h] <= (r_mtime >= r_mtimecmp[h]);
        end
    end

    assign iob_ready_o  = r_ready;
    assign iob_rvalid_o = r_rvalid;
    assign iob_rdata_o  = r_rdata;
    assign mtip_o       = r_mtip;
    assign msip_o       = r_msip;
`ifdef IOB_ACLINT_SSWI_EN
    assign ssip_o       = r_ssip;
`endif

endmodule
